// File: rtl/secuenciador_sel.sv
// Scan controller for a 4:1 channel selector: steps o_Sel through 0..3, dwells DWELL cycles per channel, samples i_Salida.
// Optional per-channel sample bank on o_Banco when SECUENCIADOR_BANCO_EN is defined.
module secuenciador_sel #(
  parameter int DATA_W  = 4,
  parameter int DWELL   = 5,
  parameter int DWELL_W = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic              i_Stop,
  input  logic              i_Modo,
  input  logic [DATA_W-1:0] i_Salida,
  output logic [1:0]        o_Sel,
  output logic [DATA_W-1:0] o_Dato,
  output logic [1:0]        o_Canal,
  output logic              o_Valido,
  output logic              o_Ocupado,
`ifdef SECUENCIADOR_BANCO_EN
  output logic [4*DATA_W-1:0] o_Banco,
`endif
  output logic              o_Fin
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

  state_t              state_q, state_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   dato_q, dato_d;
  logic [1:0]          canal_q, canal_d;
  logic                valido_q, valido_d;
  logic                fin_q, fin_d;
  logic                ocupado_q, ocupado_d;
  logic                modo_q, modo_d;
  logic                capture;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    dato_d   = dato_q;
    canal_d  = canal_q;
    modo_d   = modo_q;
    valido_d = 1'b0;
    fin_d    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = 2'd0;
        cnt_d = '0;
        if (i_Start && !i_Stop) begin
          state_d = ST_RUN;
          modo_d  = i_Modo;
        end
      end
      ST_RUN: begin
        // Stop takes priority over a capture falling on the same edge.
        if (i_Stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
          capture  = 1'b1;
          dato_d   = i_Salida;
          canal_d  = sel_q;
          valido_d = 1'b1;
          cnt_d    = '0;
          sel_d    = sel_q + 2'd1;
          if (sel_q == 2'd3) begin
            fin_d = 1'b1;
            if (!modo_q) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ocupado_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      dato_q    <= '0;
      canal_q   <= 2'd0;
      valido_q  <= 1'b0;
      fin_q     <= 1'b0;
      ocupado_q <= 1'b0;
      modo_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      dato_q    <= dato_d;
      canal_q   <= canal_d;
      valido_q  <= valido_d;
      fin_q     <= fin_d;
      ocupado_q <= ocupado_d;
      modo_q    <= modo_d;
    end
  end

`ifdef SECUENCIADOR_BANCO_EN
  logic [4*DATA_W-1:0] banco_q, banco_d;

  always_comb begin
    banco_d = banco_q;
    if (capture) begin
      banco_d[sel_q*DATA_W +: DATA_W] = i_Salida;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      banco_q <= '0;
    end else begin
      banco_q <= banco_d;
    end
  end

  assign o_Banco = banco_q;
`endif

  assign o_Sel     = sel_q;
  assign o_Dato    = dato_q;
  assign o_Canal   = canal_q;
  assign o_Valido  = valido_q;
  assign o_Fin     = fin_q;
  assign o_Ocupado = ocupado_q;

endmodule
